turn_sequencer: RTL and testbench

- Game controller that sequences turns for 2-4 players: requests a dice roll, computes the landing square, queries the board jump table (snakes/ladders), commits the new position, detects the winner and hands the turn over.
- Sits between the dice block (roll handshake) and a board jump-table block (query handshake).
- Owns all player position registers.

---
 rtl/turn_sequencer.sv | 176 +++++++++++++++++
 tb/tb_turn_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// turn_sequencer: dice-roll / jump-table turn controller for 2-4 players.
// Rev 1.0
// ----------------------------------------------------------------------------
module turn_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int BOARD_MAX   = 100,
  parameter int POS_W       = 7,
  parameter int MAX_BONUS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         roll_req,
  input  logic                         roll_valid,
  input  logic [2:0]                   roll_value,
  output logic                         jump_req,
  output logic [POS_W-1:0]             jump_query,
  input  logic                         jump_ack,
  input  logic [POS_W-1:0]             jump_dest,
  output logic [NUM_PLAYERS*POS_W-1:0] positions,
  output logic [1:0]                   cur_player,
  output logic                         move_done,
  output logic                         bad_roll,
  output logic [1:0]                   winner,
  output logic                         game_over
);

  localparam int               BON_W       = (MAX_BONUS > 0) ? $clog2(MAX_BONUS + 1) : 1;
  localparam logic [POS_W:0]   MAX_T       = (POS_W+1)'(BOARD_MAX);
  localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [BON_W-1:0] BON_MAX     = BON_W'(MAX_BONUS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ROLL  = 3'd1;
  localparam logic [2:0] S_JUMP  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q [NUM_PLAYERS];
  logic [POS_W-1:0] pos_d [NUM_PLAYERS];
  logic [1:0]       cur_q, cur_d;
  logic [BON_W-1:0] bonus_q, bonus_d;
  logic [POS_W-1:0] query_q, query_d;
  logic             six_q, six_d;
  logic             move_done_q, move_done_d;
  logic             bad_roll_q, bad_roll_d;
  logic [1:0]       winner_q, winner_d;

  logic [POS_W-1:0] w_cur_pos;
  logic [POS_W:0]   w_target;
  logic             w_roll_ok;

  always_comb begin
    w_cur_pos = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (cur_q == 2'(i)) w_cur_pos = pos_q[i];
    end
  end

  // Extra bit keeps overshoot past BOARD_MAX visible even near the top of the range.
  assign w_target  = {1'b0, w_cur_pos} + (POS_W+1)'(roll_value);
  assign w_roll_ok = (roll_value != 3'd0) && (roll_value != 3'd7);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    cur_d       = cur_q;
    bonus_d     = bonus_q;
    query_d     = query_q;
    six_d       = six_q;
    move_done_d = 1'b0;
    bad_roll_d  = 1'b0;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ROLL;
          for (int i = 0; i < NUM_PLAYERS; i++) pos_d[i] = '0;
          cur_d    = 2'd0;
          bonus_d  = '0;
          six_d    = 1'b0;
          winner_d = 2'd0;
        end
      end
      S_ROLL: begin
        if (roll_valid) begin
          if (!w_roll_ok) begin
            bad_roll_d = 1'b1;
          end else begin
            six_d = (roll_value == 3'd6);
            if (w_target > MAX_T) begin
              move_done_d = 1'b1;
              state_d     = S_NEXT;
            end else begin
              query_d = w_target[POS_W-1:0];
              state_d = S_JUMP;
            end
          end
        end
      end
      S_JUMP: begin
        if (jump_ack) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (cur_q == 2'(i))
              pos_d[i] = ({1'b0, jump_dest} > MAX_T) ? query_q : jump_dest;
          end
          move_done_d = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if ({1'b0, w_cur_pos} == MAX_T) begin
          state_d  = S_DONE;
          winner_d = cur_q;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (six_q && (bonus_q < BON_MAX)) begin
          bonus_d = bonus_q + 1'b1;
        end else begin
          bonus_d = '0;
          cur_d   = (cur_q == LAST_PLAYER) ? 2'd0 : cur_q + 2'd1;
        end
        state_d = S_ROLL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
      cur_q       <= 2'd0;
      bonus_q     <= '0;
      query_q     <= '0;
      six_q       <= 1'b0;
      move_done_q <= 1'b0;
      bad_roll_q  <= 1'b0;
      winner_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cur_q       <= cur_d;
      bonus_q     <= bonus_d;
      query_q     <= query_d;
      six_q       <= six_d;
      move_done_q <= move_done_d;
      bad_roll_q  <= bad_roll_d;
      winner_q    <= winner_d;
    end
  end

  generate
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
      assign positions[g*POS_W +: POS_W] = pos_q[g];
    end
  endgenerate

  assign roll_req   = (state_q == S_ROLL);
  assign jump_req   = (state_q == S_JUMP);
  assign jump_query = query_q;
  assign cur_player = cur_q;
  assign move_done  = move_done_q;
  assign bad_roll   = bad_roll_q;
  assign winner     = winner_q;
  assign game_over  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_turn_sequencer: directed turns with a move/bad-roll scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_turn_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        roll_req;
  logic        roll_valid = 1'b0;
  logic [2:0]  roll_value = 3'd0;
  logic        jump_req;
  logic [6:0]  jump_query;
  logic        jump_ack = 1'b0;
  logic [6:0]  jump_dest = 7'd0;
  logic [13:0] positions;
  logic [1:0]  cur_player;
  logic        move_done;
  logic        bad_roll;
  logic [1:0]  winner;
  logic        game_over;

  turn_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .roll_req(roll_req), .roll_valid(roll_valid), .roll_value(roll_value),
    .jump_req(jump_req), .jump_query(jump_query), .jump_ack(jump_ack), .jump_dest(jump_dest),
    .positions(positions), .cur_player(cur_player), .move_done(move_done),
    .bad_roll(bad_roll), .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  p;
    logic [13:0] v;
  } mv_t;

  mv_t         mq[$];
  logic [13:0] bq[$];
  logic [13:0] exp_vec = '0;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every move_done / bad_roll pulse must match the oldest queued expectation.
  initial begin
    mv_t         e;
    logic [13:0] b;
    forever begin
      @(negedge clk);
      if (move_done) begin
        if (mq.size() == 0) begin
          chk("unexpected move_done", 32'd1, 32'd0);
        end else begin
          e = mq.pop_front();
          chk("move player", 32'(cur_player), 32'(e.p));
          chk("move positions", 32'(positions), 32'(e.v));
        end
      end
      if (bad_roll) begin
        if (bq.size() == 0) begin
          chk("unexpected bad_roll", 32'd1, 32'd0);
        end else begin
          b = bq.pop_front();
          chk("bad_roll positions", 32'(positions), 32'(b));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_roll();
    int n = 0;
    while (!roll_req && n < 50) begin
      tick();
      n++;
    end
    if (!roll_req) chk("roll_req timeout", 32'(roll_req), 32'd1);
  endtask

  task automatic turn(input logic [2:0] rv, input logic [6:0] q, input logic [6:0] d,
                      input logic [1:0] p, input logic [6:0] np, input bit jumps);
    mv_t e;
    wait_roll();
    chk("turn owner", 32'(cur_player), 32'(p));
    exp_vec[p*7 +: 7] = np;
    e.p = p;
    e.v = exp_vec;
    mq.push_back(e);
    roll_valid = 1'b1;
    roll_value = rv;
    tick();
    roll_valid = 1'b0;
    chk("jump_req after roll", 32'(jump_req), 32'(jumps));
    if (jumps) begin
      chk("jump_query", 32'(jump_query), 32'(q));
      tick();
      jump_dest = d;
      jump_ack  = 1'b1;
      tick();
      jump_ack  = 1'b0;
    end
  endtask

  task automatic badroll(input logic [2:0] rv);
    wait_roll();
    bq.push_back(exp_vec);
    roll_valid = 1'b1;
    roll_value = rv;
    tick();
    roll_valid = 1'b0;
    chk("still in ROLL after bad roll", 32'(roll_req), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("reset roll_req", 32'(roll_req), 32'd0);
    chk("reset jump_req", 32'(jump_req), 32'd0);
    chk("reset positions", 32'(positions), 32'd0);
    chk("reset game_over", 32'(game_over), 32'd0);
    chk("reset cur_player", 32'(cur_player), 32'd0);
    chk("reset winner", 32'(winner), 32'd0);

    pulse_start();
    chk("roll_req after start", 32'(roll_req), 32'd1);

    turn(3, 3, 3, 0, 3, 1);
    chk("roll_req ack+1", 32'(roll_req), 32'd0);
    tick();
    chk("roll_req ack+2", 32'(roll_req), 32'd0);
    tick();
    chk("roll_req ack+3", 32'(roll_req), 32'd1);
    chk("turn passes to P1", 32'(cur_player), 32'd1);

    turn(5, 5, 15, 1, 15, 1);
    turn(3, 6, 6, 0, 6, 1);
    turn(2, 17, 7, 1, 7, 1);     // snake
    turn(3, 9, 31, 0, 31, 1);    // ladder

    wait_roll();
    pulse_start();
    chk("start ignored: cur_player", 32'(cur_player), 32'd1);
    chk("start ignored: positions", 32'(positions), 32'(exp_vec));

    turn(1, 8, 8, 1, 8, 1);
    turn(6, 37, 37, 0, 37, 1);
    turn(6, 43, 43, 0, 43, 1);
    turn(6, 49, 49, 0, 49, 1);
    turn(4, 12, 12, 1, 12, 1);
    turn(6, 55, 55, 0, 55, 1);
    turn(1, 56, 56, 0, 56, 1);

    badroll(0);
    badroll(7);
    turn(2, 14, 14, 1, 14, 1);

    turn(1, 57, 97, 0, 97, 1);
    turn(1, 15, 120, 1, 15, 1);  // out-of-range dest commits the query
    turn(5, 0, 0, 0, 97, 0);     // overshoot
    turn(6, 21, 21, 1, 21, 1);
    turn(1, 22, 22, 1, 22, 1);
    turn(3, 100, 100, 0, 100, 1);

    tick();
    chk("game_over", 32'(game_over), 32'd1);
    chk("winner", 32'(winner), 32'd0);
    chk("roll_req in DONE", 32'(roll_req), 32'd0);
    roll_valid = 1'b1;
    roll_value = 3'd2;
    tick();
    tick();
    tick();
    roll_valid = 1'b0;
    chk("DONE holds positions", 32'(positions), 32'(exp_vec));
    chk("DONE holds game_over", 32'(game_over), 32'd1);

    pulse_start();
    exp_vec = '0;
    chk("restart positions", 32'(positions), 32'd0);
    chk("restart cur_player", 32'(cur_player), 32'd0);
    chk("restart game_over", 32'(game_over), 32'd0);

    wait_roll();
    roll_valid = 1'b1;
    roll_value = 3'd4;
    tick();
    roll_valid = 1'b0;
    chk("jump_req before reset", 32'(jump_req), 32'd1);
    reset     = 1'b1;
    jump_dest = 7'd4;
    jump_ack  = 1'b1;
    tick();
    reset    = 1'b0;
    jump_ack = 1'b0;
    chk("reset mid-jump jump_req", 32'(jump_req), 32'd0);
    chk("reset mid-jump roll_req", 32'(roll_req), 32'd0);
    chk("reset mid-jump positions", 32'(positions), 32'd0);
    chk("reset mid-jump cur_player", 32'(cur_player), 32'd0);

    pulse_start();
    turn(2, 2, 2, 0, 2, 1);
    repeat (4) tick();
    chk("pending moves", 32'(mq.size()), 32'd0);
    chk("pending bad rolls", 32'(bq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
